// File: rtl/ntt_core_bfly_seq.sv
// ntt_core_bfly_seq: sequences stage/group butterfly control words for an N-point NTT
module ntt_core_bfly_seq #(
  parameter int PSI        = 4,
  parameter int N          = 1024,
  parameter int PIPE_DRAIN = 8
) (
  input  logic                                                         clk,
  input  logic                                                         a_rst,
  input  logic                                                         cmd_vld,
  input  logic                                                         cmd_fwd,
  output logic                                                         cmd_rdy,
  output logic                                                         bfly_vld,
  input  logic                                                         bfly_rdy,
  output logic [(($clog2($clog2(N)) > 1) ? $clog2($clog2(N)) : 1)-1:0] bfly_stg,
  output logic [(($clog2(N/(2*PSI)) > 1) ? $clog2(N/(2*PSI)) : 1)-1:0] bfly_grp,
  output logic [(($clog2(N) > 2) ? $clog2(N)-1 : 1)-1:0]               bfly_tw,
  output logic                                                         bfly_fwd,
  output logic                                                         bfly_sos,
  output logic                                                         bfly_eos,
  output logic                                                         bfly_eop,
  output logic                                                         busy,
  output logic                                                         done
);
  localparam int STG_NB = $clog2(N);
  localparam int GRP_NB = N / (2 * PSI);
  localparam int STG_W  = ($clog2(STG_NB) > 1) ? $clog2(STG_NB) : 1;
  localparam int GRP_W  = ($clog2(GRP_NB) > 1) ? $clog2(GRP_NB) : 1;
  localparam int TW_W   = (STG_NB > 2) ? STG_NB - 1 : 1;
  localparam logic [7:0] DRN_INIT = 8'((PIPE_DRAIN > 0) ? PIPE_DRAIN - 1 : 0);
  typedef enum logic [2:0] {IDLE, RUN, GAP, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic [STG_W-1:0] stg_q, stg_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic             fwd_q, fwd_d;
  logic [7:0]       drn_q, drn_d;
  logic             eos, last_stg, eop;
  assign eos      = grp_q == GRP_W'(GRP_NB - 1);
  assign last_stg = fwd_q ? (stg_q == STG_W'(STG_NB - 1)) : (stg_q == '0);
  assign eop      = eos && last_stg;
  assign cmd_rdy  = state_q == IDLE;
  assign bfly_vld = state_q == RUN;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign bfly_stg = stg_q;
  assign bfly_grp = grp_q;
  assign bfly_fwd = fwd_q;
  assign bfly_sos = grp_q == '0;
  assign bfly_eos = eos;
  assign bfly_eop = eop;
  assign bfly_tw  = TW_W'((32'(grp_q) * PSI) >> (STG_NB - 1 - 32'(stg_q)));
  // next-state: command latch, group/stage stepping on transfers, inter-stage and final drain timing
  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    grp_d   = grp_q;
    fwd_d   = fwd_q;
    drn_d   = drn_q;
    case (state_q)
      IDLE: if (cmd_vld) begin
        fwd_d   = cmd_fwd;
        grp_d   = '0;
        stg_d   = cmd_fwd ? '0 : STG_W'(STG_NB - 1);
        state_d = RUN;
      end
      RUN: if (bfly_rdy) begin
        grp_d = eos ? '0 : grp_q + 1'b1;
        if (eos && !eop) stg_d = fwd_q ? stg_q + 1'b1 : stg_q - 1'b1;
        if (eos) begin
          drn_d   = DRN_INIT;
          state_d = eop ? ((PIPE_DRAIN == 0) ? DONE : DRAIN) : ((PIPE_DRAIN == 0) ? RUN : GAP);
        end
      end
      GAP: begin
        state_d = (drn_q == '0) ? RUN : GAP;
        drn_d   = (drn_q == '0) ? drn_q : drn_q - 1'b1;
      end
      DRAIN: begin
        state_d = (drn_q == '0) ? DONE : DRAIN;
        drn_d   = (drn_q == '0) ? drn_q : drn_q - 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and counter registers, cleared asynchronously
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= IDLE;
      stg_q   <= '0;
      grp_q   <= '0;
      fwd_q   <= 1'b0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      grp_q   <= grp_d;
      fwd_q   <= fwd_d;
      drn_q   <= drn_d;
    end
  end
endmodule

// File: tb/tb_ntt_core_bfly_seq.sv
// tb_ntt_core_bfly_seq: table-driven scoreboard bench for the butterfly sequencer
module tb_ntt_core_bfly_seq;
  localparam int N = 16, PSI = 4, PD = 3;
  localparam int STG_NB = 4, GRP_NB = 2;
  typedef struct { logic fwd; int stall_idx; int stall_len; logic hold; int exp_done; } vec_t;
  typedef struct { logic [9:0] w; int cyc; } sb_t;
  logic clk = 1'b0, a_rst = 1'b1;
  logic cmd_vld = 1'b0, cmd_fwd = 1'b0, bfly_rdy = 1'b1;
  logic cmd_rdy, bfly_vld, bfly_fwd, bfly_sos, bfly_eos, bfly_eop, busy, done;
  logic [1:0] bfly_stg;
  logic [0:0] bfly_grp;
  logic [2:0] bfly_tw;
  logic z_cmd_vld = 1'b0, z_cmd_fwd = 1'b0, z_bfly_rdy = 1'b1;
  logic z_cmd_rdy, z_bfly_vld, z_bfly_fwd, z_bfly_sos, z_bfly_eos, z_bfly_eop, z_busy, z_done;
  logic [1:0] z_bfly_stg;
  logic [0:0] z_bfly_grp;
  logic [2:0] z_bfly_tw;
  int tests = 0, fails = 0;
  sb_t sb[$];
  vec_t tbl[6];
  always #5 clk = ~clk;
  ntt_core_bfly_seq #(.PSI(PSI), .N(N), .PIPE_DRAIN(PD)) dut (
    .clk(clk), .a_rst(a_rst), .cmd_vld(cmd_vld), .cmd_fwd(cmd_fwd), .cmd_rdy(cmd_rdy),
    .bfly_vld(bfly_vld), .bfly_rdy(bfly_rdy), .bfly_stg(bfly_stg), .bfly_grp(bfly_grp),
    .bfly_tw(bfly_tw), .bfly_fwd(bfly_fwd), .bfly_sos(bfly_sos), .bfly_eos(bfly_eos),
    .bfly_eop(bfly_eop), .busy(busy), .done(done));
  ntt_core_bfly_seq #(.PSI(PSI), .N(N), .PIPE_DRAIN(0)) dut0 (
    .clk(clk), .a_rst(a_rst), .cmd_vld(z_cmd_vld), .cmd_fwd(z_cmd_fwd), .cmd_rdy(z_cmd_rdy),
    .bfly_vld(z_bfly_vld), .bfly_rdy(z_bfly_rdy), .bfly_stg(z_bfly_stg), .bfly_grp(z_bfly_grp),
    .bfly_tw(z_bfly_tw), .bfly_fwd(z_bfly_fwd), .bfly_sos(z_bfly_sos), .bfly_eos(z_bfly_eos),
    .bfly_eop(z_bfly_eop), .busy(z_busy), .done(z_done));
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_rst(input string tag);
    check({tag, "_cmd_rdy"}, 32'(cmd_rdy), 1);
    check({tag, "_vld"}, 32'(bfly_vld), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_word"}, 32'({bfly_stg, bfly_grp, bfly_tw, bfly_sos, bfly_eos, bfly_eop, bfly_fwd}), 32'(10'b00_0_000_1_0_0_0));
  endtask
  task automatic push_model(input logic fwd, input int sidx, input int slen);
    int i, st, tw;
    logic eos;
    sb_t e;
    i = 0;
    for (int s = 0; s < STG_NB; s++)
      for (int g = 0; g < GRP_NB; g++) begin
        st    = fwd ? s : STG_NB - 1 - s;
        tw    = (g * PSI) >> (STG_NB - 1 - st);
        eos   = (g == GRP_NB - 1);
        e.w   = {2'(st), 1'(g), 3'(tw), g == 0, eos, eos && (s == STG_NB - 1), fwd};
        e.cyc = 1 + s * (GRP_NB + PD) + g + ((sidx >= 0 && i >= sidx) ? slen : 0);
        sb.push_back(e);
        i++;
      end
  endtask
  task automatic run(input vec_t v);
    int c, xi, left, bad;
    logic got_done;
    sb_t e;
    @(negedge clk);
    check("cmd_rdy_start", 32'(cmd_rdy), 1);
    cmd_vld = 1'b1;
    cmd_fwd = v.fwd;
    push_model(v.fwd, v.stall_idx, v.stall_len);
    c = 0; xi = 0; left = v.stall_len; bad = 0; got_done = 1'b0;
    while (c < 200 && !got_done) begin
      @(negedge clk);
      c++;
      cmd_vld = v.hold;
      if (c <= v.exp_done && (!busy || cmd_rdy)) bad++;
      bfly_rdy = 1'b1;
      if (bfly_vld) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_underflow: unexpected word 0x%0h at cycle %0d", {bfly_stg, bfly_grp, bfly_tw}, c);
        end else begin
          e = sb[0];
          check("word", 32'({bfly_stg, bfly_grp, bfly_tw, bfly_sos, bfly_eos, bfly_eop, bfly_fwd}), 32'(e.w));
          if (xi == v.stall_idx && left > 0) begin
            bfly_rdy = 1'b0;
            left--;
          end else begin
            check("xfer_cycle", 32'(c), 32'(e.cyc));
            void'(sb.pop_front());
            xi++;
          end
        end
      end
      if (done) begin
        got_done = 1'b1;
        check("done_cycle", 32'(c), 32'(v.exp_done));
        check("sb_empty", 32'(sb.size()), 0);
      end
    end
    if (!got_done) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done within %0d cycles, required at %0d", c, v.exp_done);
    end
    check("busy_window", 32'(bad), 0);
    bfly_rdy = 1'b1;
    sb.delete();
  endtask
  initial begin
    logic [10:0] vv, dv, ev;
    int nd, nb;
    tbl[0] = '{1'b1, -1, 0, 1'b0, 21};
    tbl[1] = '{1'b0, -1, 0, 1'b0, 21};
    tbl[2] = '{1'b1, 3, 5, 1'b0, 26};
    tbl[3] = '{1'b0, 0, 2, 1'b0, 23};
    tbl[4] = '{1'b1, -1, 0, 1'b1, 21};
    tbl[5] = '{1'b0, -1, 0, 1'b0, 21};
    repeat (2) @(negedge clk);
    chk_rst("por");
    a_rst = 1'b0;
    for (int i = 0; i < 6; i++) run(tbl[i]);
    cmd_vld = 1'b0;
    @(negedge clk);
    cmd_vld = 1'b1;
    cmd_fwd = 1'b1;
    repeat (7) begin
      @(negedge clk);
      cmd_vld = 1'b0;
    end
    check("mid_busy_before_rst", 32'(busy), 1);
    a_rst = 1'b1;
    #1;
    chk_rst("mid");
    @(negedge clk);
    a_rst = 1'b0;
    nd = 0; nb = 0;
    repeat (25) begin
      @(negedge clk);
      nd += int'(done);
      nb += int'(busy);
    end
    check("abort_no_done", 32'(nd), 0);
    check("abort_idle", 32'(nb), 0);
    run(tbl[0]);
    @(negedge clk);
    z_cmd_vld = 1'b1;
    z_cmd_fwd = 1'b1;
    vv = '0; dv = '0; ev = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      z_cmd_vld = 1'b0;
      vv[c] = z_bfly_vld;
      dv[c] = z_done;
      ev[c] = z_bfly_eop;
    end
    check("pd0_vld", 32'(vv), 32'h1FE);
    check("pd0_done", 32'(dv), 32'h200);
    check("pd0_eop", 32'(ev), 32'h100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
